pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Drives the enable/flush

---
 rtl/Pipe_Buf_Reg_PKG.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/Pipe_Buf_Reg_PKG.sv
// Pipe_Buf_Reg_PKG
//   Shared definitions for the RV32I pipeline buffer registers and the
//   hazard sequencer that drives their enables and flushes.
//   hz_state_e : hazard sequencer state (RUN / LU_STALL / MEM_WAIT)
//   NOP_INSTR  : canonical NOP (addi x0,x0,0) loaded into IF/ID on a flush
package Pipe_Buf_Reg_PKG;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage RV32I pipeline. Resolves
//   load-use hazards, EX-stage redirects and multi-cycle data-memory waits by
//   driving the PC enable and the buffer-register enables/flushes. Control
//   outputs are combinational from the registered state and the current
//   inputs, so a stall takes effect in the cycle it is detected.
//   Priority per cycle: memory wait > redirect > load-use.
//
// Parameters
//   LU_STALL_CYCLES  bubbles inserted per load-use hazard (1..3)
//   MEM_TIMEOUT      dmem wait cycles before mem_timeout is raised (2..255)
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   if_id_instr       instruction in IF/ID (rs1=[19:15], rs2=[24:20])
//   id_ex_memread     ID/EX holds a load
//   id_ex_rd          ID/EX destination register
//   ex_redirect       EX resolved a taken branch / jal / jalr
//   dmem_req          MEM stage is accessing data memory
//   dmem_ack          data memory completes the access this cycle
//   pc_en, if_id_en   PC / IF/ID load enables
//   if_id_flush       IF/ID becomes NOP on next edge
//   id_ex_flush       ID/EX becomes a bubble on next edge
//   ex_mem_en         EX/MEM load enable (ID/EX holds when low)
//   mem_wb_bubble     MEM/WB loads RegWrite=0
//   mem_timeout       sticky: a dmem wait reached MEM_TIMEOUT cycles
//   ctrl_state        current sequencer state (debug)
//   stall_cycles      cycles with pc_en=0 (PIPE_PERF_CNT_EN only, else 0)
//   flush_count       redirect flushes (PIPE_PERF_CNT_EN only, else 0)
//
// Build option
//   PIPE_PERF_CNT_EN  enables the two 32-bit wrapping performance counters.
module pipe_hazard_ctrl
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_id_instr,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_rd,
    input  logic        ex_redirect,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_en,
    output logic        mem_wb_bubble,
    output logic        mem_timeout,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    // Bubbles still owed after the first one, which is inserted in RUN.
    localparam logic [1:0] LU_EXTRA = 2'(LU_STALL_CYCLES - 1);
    localparam logic [7:0] TMO      = 8'(MEM_TIMEOUT);

    hz_state_e   state_q, state_d;
    logic [1:0]  lu_cnt_q, lu_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_d;
    logic        lu;
    logic        mem_miss;

    // A flushed IF/ID slot (canonical NOP) never reads a register.
    assign lu = id_ex_memread && (id_ex_rd != 5'd0) &&
                (if_id_instr != NOP_INSTR) &&
                ((id_ex_rd == if_id_instr[19:15]) || (id_ex_rd == if_id_instr[24:20]));

    assign mem_miss = dmem_req && !dmem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            lu_cnt_q    <= 2'd0;
            wait_cnt_q  <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_timeout <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lu_cnt_d      = lu_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;

        case (state_q)
            RUN, LU_STALL: begin
                if (mem_miss) begin
                    // Freeze everything upstream of MEM; owed bubbles are kept.
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    wait_cnt_d    = 8'd1;
                    state_d       = MEM_WAIT;
                end else if (state_q == LU_STALL) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    lu_cnt_d    = lu_cnt_q - 2'd1;
                    if (lu_cnt_q == 2'd1) state_d = RUN;
                end else if (ex_redirect) begin
                    // Flushing both younger slots also discards any stalled consumer.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (lu) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    if (LU_EXTRA != 2'd0) begin
                        lu_cnt_d = LU_EXTRA;
                        state_d  = LU_STALL;
                    end
                end
            end
            MEM_WAIT: begin
                if (!dmem_ack) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    wait_cnt_d    = (wait_cnt_q >= TMO) ? TMO : wait_cnt_q + 8'd1;
                end else begin
                    // Access completes: pipeline moves on, front end resolves
                    // whatever the frozen ID/EX and IF/ID were holding.
                    wait_cnt_d = 8'd0;
                    state_d    = RUN;
                    if (lu_cnt_q != 2'd0) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        lu_cnt_d    = lu_cnt_q - 2'd1;
                        if (lu_cnt_q != 2'd1) state_d = LU_STALL;
                    end else if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (lu) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        if (LU_EXTRA != 2'd0) begin
                            lu_cnt_d = LU_EXTRA;
                            state_d  = LU_STALL;
                        end
                    end
                end
            end
            default: begin
                state_d  = RUN;
                lu_cnt_d = 2'd0;
            end
        endcase

        mem_timeout_d = mem_timeout || (wait_cnt_d == TMO);

        // While held in reset the pipeline is frozen and filled with bubbles.
        if (!reset) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end
    end

    assign ctrl_state = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;
    logic        redirect_flush;

    // Outside reset only a redirect raises if_id_flush with the PC running.
    assign redirect_flush = if_id_flush && pc_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (!pc_en)         stall_q <= stall_q + 32'd1;
            if (redirect_flush) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with a single load-use
// bubble and one with three, driven from the same inputs.
module tb_pipe_hazard_ctrl;
    import Pipe_Buf_Reg_PKG::*;

    // Control vector {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_bubble}
    localparam logic [5:0] C_N = 6'b110010;  // normal flow
    localparam logic [5:0] C_S = 6'b000110;  // load-use bubble
    localparam logic [5:0] C_F = 6'b000001;  // memory wait freeze
    localparam logic [5:0] C_R = 6'b111110;  // redirect flush
    localparam logic [5:0] C_Z = 6'b001101;  // held in reset

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_LU  = 2'd1;
    localparam logic [1:0] S_MW  = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_id_instr;
    logic        id_ex_memread;
    logic [4:0]  id_ex_rd;
    logic        ex_redirect;
    logic        dmem_req;
    logic        dmem_ack;

    logic        a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush, a_ex_mem_en, a_mem_wb_bubble, a_mem_timeout;
    logic [1:0]  a_state;
    logic [31:0] a_stall, a_flush;
    logic        b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_flush, b_ex_mem_en, b_mem_wb_bubble, b_mem_timeout;
    logic [1:0]  b_state;
    logic [31:0] b_stall, b_flush;

    int n_checks = 0;
    int n_errors = 0;
    int exp_stall_a = 0, exp_stall_b = 0, exp_flush_a = 0, exp_flush_b = 0;

    // add x6,x5,x1 : rs1=5, rs2=1 ; addi x6,x0,5 : rs1=0
    logic [31:0] add_x6_x5_x1;
    logic [31:0] addi_x6_x0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(16)) u_dut_a (
        .clk(clk), .reset(reset), .if_id_instr(if_id_instr), .id_ex_memread(id_ex_memread),
        .id_ex_rd(id_ex_rd), .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(a_pc_en), .if_id_en(a_if_id_en), .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
        .ex_mem_en(a_ex_mem_en), .mem_wb_bubble(a_mem_wb_bubble), .mem_timeout(a_mem_timeout),
        .ctrl_state(a_state), .stall_cycles(a_stall), .flush_count(a_flush)
    );

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(16)) u_dut_b (
        .clk(clk), .reset(reset), .if_id_instr(if_id_instr), .id_ex_memread(id_ex_memread),
        .id_ex_rd(id_ex_rd), .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(b_pc_en), .if_id_en(b_if_id_en), .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
        .ex_mem_en(b_ex_mem_en), .mem_wb_bubble(b_mem_wb_bubble), .mem_timeout(b_mem_timeout),
        .ctrl_state(b_state), .stall_cycles(b_stall), .flush_count(b_flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl_a();
        return {a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush, a_ex_mem_en, a_mem_wb_bubble};
    endfunction

    function automatic logic [5:0] ctl_b();
        return {b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_flush, b_ex_mem_en, b_mem_wb_bubble};
    endfunction

    task automatic set_in(input logic [31:0] instr, input logic mr, input logic [4:0] rd,
                          input logic redir, input logic req, input logic ack);
        if_id_instr   = instr;
        id_ex_memread = mr;
        id_ex_rd      = rd;
        ex_redirect   = redir;
        dmem_req      = req;
        dmem_ack      = ack;
    endtask

    // One clock: control outputs checked at the falling edge, state after the rising edge.
    task automatic cyc(input string tag, input logic [5:0] ea, input logic [1:0] sa,
                       input logic [5:0] eb, input logic [1:0] sb);
        @(negedge clk);
        check({tag, ".ctl_a"}, 32'(ctl_a()), 32'(ea));
        check({tag, ".ctl_b"}, 32'(ctl_b()), 32'(eb));
        if (!ea[5]) exp_stall_a++;
        if (!eb[5]) exp_stall_b++;
        if (ea == C_R) exp_flush_a++;
        if (eb == C_R) exp_flush_b++;
        @(posedge clk);
        #1;
        check({tag, ".state_a"}, 32'(a_state), 32'(sa));
        check({tag, ".state_b"}, 32'(b_state), 32'(sb));
    endtask

    task automatic check_counters(input string tag);
`ifdef PIPE_PERF_CNT_EN
        check({tag, ".stall_a"}, a_stall, 32'(exp_stall_a));
        check({tag, ".stall_b"}, b_stall, 32'(exp_stall_b));
        check({tag, ".flush_a"}, a_flush, 32'(exp_flush_a));
        check({tag, ".flush_b"}, b_flush, 32'(exp_flush_b));
`else
        check({tag, ".stall_a"}, a_stall, 32'd0);
        check({tag, ".stall_b"}, b_stall, 32'd0);
        check({tag, ".flush_a"}, a_flush, 32'd0);
        check({tag, ".flush_b"}, b_flush, 32'd0);
`endif
    endtask

    initial begin
        add_x6_x5_x1 = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
        addi_x6_x0   = {12'd5, 5'd0, 3'd0, 5'd6, 7'b0010011};

        // Reset: outputs forced even with a redirect and a hazard present.
        reset = 1'b0;
        set_in(add_x6_x5_x1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("rst.ctl_a", 32'(ctl_a()), 32'(C_Z));
        check("rst.ctl_b", 32'(ctl_b()), 32'(C_Z));
        check("rst.state_a", 32'(a_state), 32'(S_RUN));
        check("rst.tmo_a", 32'(a_mem_timeout), 32'd0);
        check_counters("rst");
        @(posedge clk);
        #1;
        check("rst.state_b", 32'(b_state), 32'(S_RUN));
        reset = 1'b1;
        set_in(NOP_INSTR, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("idle", C_N, S_RUN, C_N, S_RUN);

        // Load-use via rs1: one bubble on a, three on b.
        set_in(add_x6_x5_x1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc("lu1.c0", C_S, S_RUN, C_S, S_LU);
        id_ex_memread = 1'b0;
        cyc("lu1.c1", C_N, S_RUN, C_S, S_LU);
        cyc("lu1.c2", C_N, S_RUN, C_S, S_RUN);
        cyc("lu1.c3", C_N, S_RUN, C_N, S_RUN);

        // x0 destination never stalls; non-matching rd never stalls.
        set_in(addi_x6_x0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("x0", C_N, S_RUN, C_N, S_RUN);
        set_in(add_x6_x5_x1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        cyc("nomatch", C_N, S_RUN, C_N, S_RUN);

        // Load-use via rs2.
        set_in(add_x6_x5_x1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
        cyc("lu2.c0", C_S, S_RUN, C_S, S_LU);
        id_ex_memread = 1'b0;
        cyc("lu2.c1", C_N, S_RUN, C_S, S_LU);
        cyc("lu2.c2", C_N, S_RUN, C_S, S_RUN);

        // Redirect and load-use together: redirect wins.
        set_in(add_x6_x5_x1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc("redir", C_R, S_RUN, C_R, S_RUN);
        set_in(NOP_INSTR, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("redir.after", C_N, S_RUN, C_N, S_RUN);

        // Memory wait: four frozen cycles, then ack.
        set_in(NOP_INSTR, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc("mw4", C_F, S_MW, C_F, S_MW);
        dmem_ack = 1'b1;
        cyc("mw4.ack", C_N, S_RUN, C_N, S_RUN);
        check("mw4.tmo_a", 32'(a_mem_timeout), 32'd0);

        // Redirect arriving during a wait is held until the ack cycle.
        set_in(NOP_INSTR, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cyc("mwr.wait", C_F, S_MW, C_F, S_MW);
        dmem_ack = 1'b1;
        cyc("mwr.ack", C_R, S_RUN, C_R, S_RUN);

        // Timeout after 16 wait cycles, sticky afterwards.
        set_in(NOP_INSTR, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc("tmo", C_F, S_MW, C_F, S_MW);
            if (i == 14) check("tmo.c15_a", 32'(a_mem_timeout), 32'd0);
        end
        check("tmo.c16_a", 32'(a_mem_timeout), 32'd1);
        check("tmo.c16_b", 32'(b_mem_timeout), 32'd1);
        dmem_ack = 1'b1;
        cyc("tmo.ack", C_N, S_RUN, C_N, S_RUN);
        set_in(NOP_INSTR, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("tmo.idle", C_N, S_RUN, C_N, S_RUN);
        check("tmo.sticky_a", 32'(a_mem_timeout), 32'd1);

        // Memory miss preempts LU_STALL; owed bubbles resume after ack.
        set_in(add_x6_x5_x1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc("pre.c0", C_S, S_RUN, C_S, S_LU);
        set_in(add_x6_x5_x1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0);
        cyc("pre.wait", C_F, S_MW, C_F, S_MW);
        dmem_ack = 1'b1;
        cyc("pre.ack", C_N, S_RUN, C_S, S_LU);
        set_in(NOP_INSTR, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("pre.last", C_N, S_RUN, C_S, S_RUN);
        check_counters("perf");

        // Reset asserted mid wait (b also owes bubbles): back to RUN at once.
        set_in(add_x6_x5_x1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc("mid.c0", C_S, S_RUN, C_S, S_LU);
        set_in(NOP_INSTR, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("mid.w0", C_F, S_MW, C_F, S_MW);
        cyc("mid.w1", C_F, S_MW, C_F, S_MW);
        #1;
        reset = 1'b0;
        #1;
        check("mid.state_a", 32'(a_state), 32'(S_RUN));
        check("mid.state_b", 32'(b_state), 32'(S_RUN));
        check("mid.ctl_a", 32'(ctl_a()), 32'(C_Z));
        check("mid.tmo_a", 32'(a_mem_timeout), 32'd0);
        exp_stall_a = 0;
        exp_stall_b = 0;
        exp_flush_a = 0;
        exp_flush_b = 0;
        check_counters("mid");
        @(posedge clk);
        #1;
        reset = 1'b1;
        dmem_req = 1'b0;
        cyc("mid.after", C_N, S_RUN, C_N, S_RUN);
        cyc("mid.after2", C_N, S_RUN, C_N, S_RUN);
        check_counters("end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
